bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arb_pkg.sv | 11 +
 rtl/bus_rr_pick.sv | 8 +
 rtl/bus_arbiter.sv | 118 +++++++++++
 tb/tb_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the two-client system-bus arbiter.
package bus_arb_pkg;
   typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_e;
   localparam int BEATS_PER_LINE = 8;
   localparam int DEFAULT_TAG_WIDTH = 13;
   localparam int TAG_DIR_BIT = DEFAULT_TAG_WIDTH - 1;
   localparam logic READ = 1'b1;
   function automatic int tag_dir_bit(input int tag_width);
      return tag_width - 1;
   endfunction
endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: two-way round-robin pick; on contention the client not granted last time wins.
module bus_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);
   assign grant = (&req) ? ~last : req[1];
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one system bus between fetch (client 0) and memory (client 1),
// routing the owner's request and an 8-beat read response back to it.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      if_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] if_req,
   input  logic [BUS_TAG_WIDTH-1:0]  if_reqtag,
   output logic                      if_reqack,
   output logic                      if_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] if_resp,
   output logic [BUS_TAG_WIDTH-1:0]  if_resptag,
   input  logic                      if_respack,
   input  logic                      mem_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] mem_req,
   input  logic [BUS_TAG_WIDTH-1:0]  mem_reqtag,
   input  logic                      mem_respack,
   output logic                      mem_reqack,
   output logic                      mem_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] mem_resp,
   output logic [BUS_TAG_WIDTH-1:0]  mem_resptag,
   output logic                      bus_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_req,
   output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_respack,
   input  logic                      bus_reqack,
   input  logic                      bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);
   localparam int DIR = tag_dir_bit(BUS_TAG_WIDTH);
   arb_state_e state_q, state_d;
   logic owner_q, owner_d;
   logic last_q, last_d;
   logic acked_q, acked_d;
   logic dir_q, dir_d;
   logic [2:0] beat_q, beat_d;
   logic pick, in_req, in_resp, beat, req_done;
   logic own_reqcyc, own_respack;
   logic [BUS_DATA_WIDTH-1:0] own_req;
   logic [BUS_TAG_WIDTH-1:0] own_reqtag;
   bus_rr_pick u_pick (
      .req   ({mem_reqcyc, if_reqcyc}),
      .last  (last_q),
      .grant (pick)
   );
   assign own_reqcyc  = owner_q ? mem_reqcyc  : if_reqcyc;
   assign own_req     = owner_q ? mem_req     : if_req;
   assign own_reqtag  = owner_q ? mem_reqtag  : if_reqtag;
   assign own_respack = owner_q ? mem_respack : if_respack;
   assign in_req   = state_q == REQ;
   assign in_resp  = state_q == RESP;
   assign beat     = in_resp & bus_respcyc & bus_respack;
   // The request ends only once the bus has acked at least once and the owner lets go.
   assign req_done = in_req & acked_q & ~own_reqcyc;
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      acked_d = acked_q;
      dir_d   = dir_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: if (if_reqcyc | mem_reqcyc) begin
            state_d = REQ;
            owner_d = pick;
            last_d  = pick;
            acked_d = 1'b0;
            dir_d   = pick ? mem_reqtag[DIR] : if_reqtag[DIR];
         end
         REQ: begin
            acked_d = acked_q | bus_reqack;
            dir_d   = own_reqcyc ? own_reqtag[DIR] : dir_q;
            beat_d  = '0;
            state_d = req_done ? ((dir_q == READ) ? RESP : IDLE) : REQ;
         end
         RESP: if (beat) begin
            beat_d  = (beat_q == 3'(BEATS_PER_LINE - 1)) ? 3'd0 : beat_q + 3'd1;
            state_d = (beat_q == 3'(BEATS_PER_LINE - 1)) ? IDLE : RESP;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b0;
         acked_q <= 1'b0;
         dir_q   <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         acked_q <= acked_d;
         dir_q   <= dir_d;
         beat_q  <= beat_d;
      end
   end
   assign bus_reqcyc  = in_req & own_reqcyc;
   assign bus_req     = in_req ? own_req : '0;
   assign bus_reqtag  = in_req ? own_reqtag : '0;
   assign if_reqack   = in_req & ~owner_q & bus_reqack;
   assign mem_reqack  = in_req & owner_q & bus_reqack;
   assign if_respcyc  = in_resp & ~owner_q & bus_respcyc;
   assign mem_respcyc = in_resp & owner_q & bus_respcyc;
   assign if_resp     = in_resp ? bus_resp : '0;
   assign mem_resp    = in_resp ? bus_resp : '0;
   assign if_resptag  = in_resp ? bus_resptag : '0;
   assign mem_resptag = in_resp ? bus_resptag : '0;
   assign bus_respack = in_resp & own_respack;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, directed corner sequences and random traffic vs a transaction-level model.
module tb_bus_arbiter;
   localparam int DW = 64;
   localparam int TW = 13;
   localparam int OW = 237;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic if_reqcyc = 0, if_respack = 0, mem_reqcyc = 0, mem_respack = 0;
   logic bus_reqack = 0, bus_respcyc = 0;
   logic [DW-1:0] if_req = '0, mem_req = '0, bus_resp = '0;
   logic [TW-1:0] if_reqtag = '0, mem_reqtag = '0, bus_resptag = '0;
   logic if_reqack, if_respcyc, mem_reqack, mem_respcyc, bus_reqcyc, bus_respack;
   logic [DW-1:0] if_resp, mem_resp, bus_req;
   logic [TW-1:0] if_resptag, mem_resptag, bus_reqtag;
   logic [OW-1:0] act_v;
   int n_chk = 0, n_err = 0;
   int m_owner, m_left;
   bit m_acked, m_read, m_pref_mem;
   bus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .if_reqcyc(if_reqcyc), .if_req(if_req), .if_reqtag(if_reqtag), .if_reqack(if_reqack),
      .if_respcyc(if_respcyc), .if_resp(if_resp), .if_resptag(if_resptag), .if_respack(if_respack),
      .mem_reqcyc(mem_reqcyc), .mem_req(mem_req), .mem_reqtag(mem_reqtag), .mem_respack(mem_respack),
      .mem_reqack(mem_reqack), .mem_respcyc(mem_respcyc), .mem_resp(mem_resp), .mem_resptag(mem_resptag),
      .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_respack(bus_respack),
      .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
   );
   always #5 clk = ~clk;
   assign act_v = {if_reqack, if_respcyc, if_resp, if_resptag, mem_reqack, mem_respcyc, mem_resp, mem_resptag,
                   bus_reqcyc, bus_req, bus_reqtag, bus_respack};
   task automatic chk(input string name, input logic [OW-1:0] a, input logic [OW-1:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask
   task automatic model_reset();
      m_owner = -1;
      m_left = 0;
      m_acked = 0;
      m_read = 0;
      m_pref_mem = 1;
   endtask
   // Owner -1 means the bus is free; m_left > 0 means a read line is still being returned.
   function automatic logic [OW-1:0] exp_outs();
      bit idle, resp, rq, om;
      logic ocyc;
      idle = m_owner < 0;
      resp = !idle && m_left > 0;
      rq = !idle && m_left == 0;
      om = m_owner == 1;
      ocyc = om ? mem_reqcyc : if_reqcyc;
      return {rq && !om && bus_reqack, resp && !om && bus_respcyc, resp ? bus_resp : 64'd0, resp ? bus_resptag : 13'd0,
              rq && om && bus_reqack, resp && om && bus_respcyc, resp ? bus_resp : 64'd0, resp ? bus_resptag : 13'd0,
              rq && ocyc, rq ? (om ? mem_req : if_req) : 64'd0, rq ? (om ? mem_reqtag : if_reqtag) : 13'd0,
              resp && (om ? mem_respack : if_respack)};
   endfunction
   task automatic model_update();
      logic ocyc;
      if (reset) begin
         model_reset();
         return;
      end
      ocyc = (m_owner == 1) ? mem_reqcyc : if_reqcyc;
      if (m_owner < 0) begin
         if (if_reqcyc || mem_reqcyc) begin
            m_owner = (if_reqcyc && mem_reqcyc) ? (m_pref_mem ? 1 : 0) : (mem_reqcyc ? 1 : 0);
            m_pref_mem = m_owner == 0;
            m_acked = 0;
            m_read = (m_owner == 1) ? mem_reqtag[TW-1] : if_reqtag[TW-1];
         end
      end else if (m_left == 0) begin
         if (m_acked && !ocyc) begin
            if (m_read) m_left = 8;
            else m_owner = -1;
         end else begin
            if (ocyc) m_read = (m_owner == 1) ? mem_reqtag[TW-1] : if_reqtag[TW-1];
            if (bus_reqack) m_acked = 1;
         end
      end else if (bus_respcyc && ((m_owner == 1) ? mem_respack : if_respack)) begin
         m_left--;
         if (m_left == 0) m_owner = -1;
      end
   endtask
   task automatic settle();
      #1;
      chk("model_outs", act_v, exp_outs());
   endtask
   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask
   task automatic cyc();
      settle();
      tick();
   endtask
   task automatic set_idle();
      if_reqcyc = 0; mem_reqcyc = 0; if_respack = 0; mem_respack = 0;
      bus_reqack = 0; bus_respcyc = 0;
      if_req = '0; mem_req = '0; if_reqtag = '0; mem_reqtag = '0; bus_resp = '0; bus_resptag = '0;
   endtask
   task automatic do_reset();
      reset = 1;
      set_idle();
      model_reset();
      cyc();
      cyc();
      reset = 0;
   endtask
   task automatic start_read(input bit mem);
      set_idle();
      if (mem) begin
         mem_reqcyc = 1; mem_reqtag = {1'b1, 12'h0c3}; mem_req = 64'hBEEF;
      end else begin
         if_reqcyc = 1; if_reqtag = {1'b1, 12'h03c}; if_req = 64'hCAFE;
      end
      cyc();
      bus_reqack = 1;
      cyc();
      mem_reqcyc = 0; if_reqcyc = 0; bus_reqack = 0;
      cyc();
   endtask
   typedef struct packed {
      logic ifc, memc, ifmsb, memmsb, bra, brc, ifra, memra;
      logic [5:0] exp;
   } vec_t;
   vec_t tbl[13];
   logic [5:0] ctl;
   int delivered, hold;
   bit done;
   initial begin
      tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 6'b000000};
      tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 6'b100000};
      tbl[2]  = '{1, 1, 0, 0, 1, 0, 0, 0, 6'b101000};
      tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 6'b000000};
      tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 6'b000000};
      tbl[5]  = '{1, 0, 0, 0, 1, 0, 0, 0, 6'b110000};
      tbl[6]  = '{0, 1, 0, 0, 1, 0, 0, 0, 6'b010000};
      tbl[7]  = '{1, 1, 0, 1, 0, 0, 0, 0, 6'b000000};
      tbl[8]  = '{1, 1, 0, 1, 1, 0, 0, 0, 6'b101000};
      tbl[9]  = '{1, 0, 0, 1, 0, 0, 0, 0, 6'b000000};
      tbl[10] = '{1, 0, 0, 0, 0, 1, 1, 1, 6'b000011};
      tbl[11] = '{1, 0, 0, 0, 0, 1, 1, 0, 6'b000010};
      tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 6'b000001};
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 13; i++) begin
         if_reqcyc = tbl[i].ifc; mem_reqcyc = tbl[i].memc;
         if_reqtag = {tbl[i].ifmsb, 12'h0ab}; mem_reqtag = {tbl[i].memmsb, 12'h0cd};
         bus_reqack = tbl[i].bra; bus_respcyc = tbl[i].brc;
         if_respack = tbl[i].ifra; mem_respack = tbl[i].memra;
         settle();
         ctl = {bus_reqcyc, if_reqack, mem_reqack, if_respcyc, mem_respcyc, bus_respack};
         chk($sformatf("vec%0d", i), ctl, tbl[i].exp);
         tick();
      end
      // IF read alone, bus acks after two cycles, eight beats 0x10..0x17
      do_reset();
      if_reqcyc = 1; if_reqtag = {1'b1, 12'h05a}; if_req = 64'hA5;
      cyc();
      settle();
      chk("grant_latency", bus_reqcyc, 1);
      tick();
      cyc();
      bus_reqack = 1;
      cyc();
      if_reqcyc = 0; bus_reqack = 0;
      cyc();
      if_respack = 1; bus_respcyc = 1;
      for (int k = 0; k < 8; k++) begin
         bus_resp = 64'h10 + 64'(k);
         settle();
         chk("if_beat_data", if_resp, 64'h10 + 64'(k));
         chk("if_beat_cyc", if_respcyc, 1);
         chk("mem_respcyc_quiet", mem_respcyc, 0);
         tick();
      end
      settle();
      chk("idle_after_8", if_respcyc, 0);
      tick();
      // response stalled by if_respack low on the third beat
      do_reset();
      start_read(0);
      bus_respcyc = 1; delivered = 0; hold = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         bus_resp = 64'(i);
         if_respack = !(delivered == 2 && hold < 2);
         settle();
         if (!if_respack) begin
            hold++;
            chk("stall_respack", bus_respack, 0);
         end
         if (if_respcyc && if_respack) delivered++;
         done = !if_respcyc;
         tick();
      end
      chk("stall_beats", 32'(delivered), 32'd8);
      chk("stall_cycles", 32'(hold), 32'd2);
      // MEM write with nine request beats
      do_reset();
      mem_reqcyc = 1; mem_reqtag = {1'b0, 12'h111}; mem_req = 64'h77; bus_reqack = 1;
      cyc();
      for (int k = 0; k < 9; k++) begin
         settle();
         chk("write_reqcyc", bus_reqcyc, 1);
         chk("write_reqack", mem_reqack, 1);
         tick();
      end
      mem_reqcyc = 0; bus_reqack = 0;
      cyc();
      bus_respcyc = 1; mem_respack = 1;
      settle();
      chk("write_no_resp", mem_respcyc, 0);
      chk("write_no_respack", bus_respack, 0);
      tick();
      // reset in the middle of a MEM read
      do_reset();
      start_read(1);
      mem_respack = 1; bus_respcyc = 1; bus_resp = 64'h99;
      for (int k = 0; k < 4; k++) cyc();
      reset = 1;
      model_reset();
      settle();
      chk("reset_outs", act_v, '0);
      tick();
      reset = 0;
      settle();
      chk("no_beat_after_reset", mem_respcyc, 0);
      tick();
      set_idle();
      if_reqcyc = 1; if_reqtag = {1'b0, 12'h222};
      cyc();
      bus_reqack = 1;
      settle();
      chk("post_reset_grant", {bus_reqcyc, if_reqack}, 2'b11);
      tick();
      if_reqcyc = 0; bus_reqack = 0;
      cyc();
      // MEM waits behind IF's read response
      do_reset();
      start_read(0);
      mem_reqcyc = 1; mem_reqtag = {1'b0, 12'h333}; if_respack = 1; bus_respcyc = 1; bus_reqack = 1;
      for (int k = 0; k < 8; k++) begin
         settle();
         chk("mem_waits", mem_reqack, 0);
         tick();
      end
      settle();
      chk("mem_waits_idle", mem_reqack, 0);
      tick();
      settle();
      chk("mem_granted", {bus_reqcyc, mem_reqack}, 2'b11);
      tick();
      mem_reqcyc = 0; bus_reqack = 0;
      cyc();
      // random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         reset = $urandom_range(0, 399) == 0;
         if (reset) model_reset();
         if_reqcyc = 1'($urandom_range(0, 1)); mem_reqcyc = 1'($urandom_range(0, 1));
         if_req = {$urandom, $urandom}; mem_req = {$urandom, $urandom};
         if_reqtag = 13'($urandom); mem_reqtag = 13'($urandom);
         bus_reqack = $urandom_range(0, 2) != 0; bus_respcyc = $urandom_range(0, 3) != 0;
         if_respack = $urandom_range(0, 3) != 0; mem_respack = $urandom_range(0, 3) != 0;
         bus_resp = {$urandom, $urandom}; bus_resptag = 13'($urandom);
         cyc();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
